// File: rtl/minhash_bottomk_sorter_if.sv
// Stream bundle between hasher, bottom-K sorter and extender.
// Input beats carry signature/index; output beats carry the sorted sketch.
interface minhash_bottomk_sorter_if #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [SIG_W-1:0] in_signature;
  logic [IDX_W-1:0] in_index;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] out_signature;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_signature, in_index, in_last,
    input  in_ready,
    input  out_valid, out_signature, out_index, out_last, out_count,
    output out_ready
  );

  modport slave (
    input  in_valid, in_signature, in_index, in_last,
    output in_ready,
    output out_valid, out_signature, out_index, out_last, out_count,
    input  out_ready
  );
endinterface

// File: rtl/minhash_bottomk_sorter.sv
// Bottom-K minhash sketch: keeps the K smallest signatures of a fragment
// sorted ascending, then drains them in order at fragment end.
module minhash_bottomk_sorter #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 8,
  parameter int K     = 4,
  parameter int DEDUP = 1,
  parameter int CNT_W = $clog2(K+1)
) (
  input logic                  clk,
  input logic                  rst_n,
  minhash_bottomk_sorter_if.slave bus
);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t           state;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [K-1:0]     vld_q, vld_d, vld_dn, vld_up;
  logic [SIG_W-1:0] sig_q [K];
  logic [SIG_W-1:0] sig_d [K];
  logic [SIG_W-1:0] sig_dn [K];
  logic [SIG_W-1:0] sig_up [K];
  logic [IDX_W-1:0] idx_q [K];
  logic [IDX_W-1:0] idx_d [K];
  logic [IDX_W-1:0] idx_dn [K];
  logic [IDX_W-1:0] idx_up [K];

  logic [CNT_W-1:0] pos;
  logic             hit;
  logic             acc;
  logic             ins;
  logic             hs;

  always_comb begin
    pos = '0;
    hit = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (vld_q[i] && sig_q[i] <= bus.in_signature)
        pos = pos + CNT_W'(1);
      if (vld_q[i] && sig_q[i] == bus.in_signature)
        hit = 1'b1;
    end
    acc = bus.in_valid && rdy_q;
    ins = acc && (pos != CNT_W'(K))
        && !((DEDUP != 0) && hit);
    hs  = (state == DRAIN) && bus.out_ready;

    // dn: slots shifted toward the tail, up: toward slot 0
    sig_dn[0] = '0;
    idx_dn[0] = '0;
    vld_dn[0] = 1'b0;
    for (int i = 1; i < K; i++) begin
      sig_dn[i] = sig_q[i-1];
      idx_dn[i] = idx_q[i-1];
      vld_dn[i] = vld_q[i-1];
    end
    sig_up[K-1] = '0;
    idx_up[K-1] = '0;
    vld_up[K-1] = 1'b0;
    for (int i = 0; i < K-1; i++) begin
      sig_up[i] = sig_q[i+1];
      idx_up[i] = idx_q[i+1];
      vld_up[i] = vld_q[i+1];
    end

    vld_d = vld_q;
    for (int i = 0; i < K; i++) begin
      sig_d[i] = sig_q[i];
      idx_d[i] = idx_q[i];
    end

    if (ins) begin
      for (int i = 0; i < K; i++) begin
        if (CNT_W'(i) == pos) begin
          sig_d[i] = bus.in_signature;
          idx_d[i] = bus.in_index;
          vld_d[i] = 1'b1;
        end else if (CNT_W'(i) > pos) begin
          sig_d[i] = sig_dn[i];
          idx_d[i] = idx_dn[i];
          vld_d[i] = vld_dn[i];
        end
      end
    end else if (hs) begin
      vld_d = vld_up;
      for (int i = 0; i < K; i++) begin
        sig_d[i] = sig_up[i];
        idx_d[i] = idx_up[i];
      end
      if (cnt_q == CNT_W'(1))
        vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      rdy_q <= 1'b0;
      cnt_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= sig_d[i];
        idx_q[i] <= idx_d[i];
      end
      case (state)
        COLLECT: begin
          rdy_q <= 1'b1;
          if (ins && cnt_q != CNT_W'(K))
            cnt_q <= cnt_q + CNT_W'(1);
          if (acc && bus.in_last) begin
            state <= DRAIN;
            rdy_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (hs) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state <= COLLECT;
              rdy_q <= 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.out_valid     = (state == DRAIN);
  assign bus.out_last      = (state == DRAIN)
                           && (cnt_q == CNT_W'(1));
  assign bus.out_signature = sig_q[0];
  assign bus.out_index     = idx_q[0];
  assign bus.out_count     = cnt_q;

endmodule

// File: tb/tb_minhash_bottomk_sorter.sv
// Directed bench for the bottom-K sorter: one DEDUP=1 and
// one DEDUP=0 instance, K=4, 32-bit signatures, 8-bit index.
module tb_minhash_bottomk_sorter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minhash_bottomk_sorter_if #(.SIG_W(32), .IDX_W(8), .CNT_W(3)) ia();
  minhash_bottomk_sorter_if #(.SIG_W(32), .IDX_W(8), .CNT_W(3)) ib();

  minhash_bottomk_sorter #(
    .SIG_W(32), .IDX_W(8), .K(4), .DEDUP(1), .CNT_W(3)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

  minhash_bottomk_sorter #(
    .SIG_W(32), .IDX_W(8), .K(4), .DEDUP(0), .CNT_W(3)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int pass = 0;
  int total = 0;
  bit cur = 1'b0;

  logic [31:0] exp_sig [8];
  logic [7:0]  exp_idx [8];

  logic        o_v, o_l, o_r;
  logic [31:0] o_s;
  logic [7:0]  o_i;
  logic [2:0]  o_c;

  assign o_v = cur ? ib.out_valid     : ia.out_valid;
  assign o_l = cur ? ib.out_last      : ia.out_last;
  assign o_r = cur ? ib.in_ready      : ia.in_ready;
  assign o_s = cur ? ib.out_signature : ia.out_signature;
  assign o_i = cur ? ib.out_index     : ia.out_index;
  assign o_c = cur ? ib.out_count     : ia.out_count;

  task automatic set_ordy(input logic v);
    if (cur) ib.out_ready = v;
    else     ia.out_ready = v;
  endtask

  task automatic push(input logic [31:0] s, input logic [7:0] i,
                      input logic l);
    total++;
    if (o_r !== 1'b1)
      $display("FAIL push_ready sig=%0d got=%b want=1", s, o_r);
    else pass++;
    if (cur) begin
      ib.in_valid = 1'b1; ib.in_signature = s;
      ib.in_index = i;    ib.in_last = l;
    end else begin
      ia.in_valid = 1'b1; ia.in_signature = s;
      ia.in_index = i;    ia.in_last = l;
    end
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ia.in_last = 1'b0;
    ib.in_valid = 1'b0; ib.in_last = 1'b0;
  endtask

  task automatic drain(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_v !== 1'b1)
        $display("FAIL %s valid[%0d] got=%b want=1", nm, k, o_v);
      else pass++;
      total++;
      if (o_s !== exp_sig[k] || o_i !== exp_idx[k])
        $display("FAIL %s data[%0d] got=%0h/%0d want=%0h/%0d",
                 nm, k, o_s, o_i, exp_sig[k], exp_idx[k]);
      else pass++;
      total++;
      if (o_l !== logic'(k == n-1))
        $display("FAIL %s last[%0d] got=%b want=%b",
                 nm, k, o_l, (k == n-1));
      else pass++;
      total++;
      if (o_c !== 3'(n-k))
        $display("FAIL %s count[%0d] got=%0d want=%0d",
                 nm, k, o_c, n-k);
      else pass++;
      set_ordy(1'b1);
      @(posedge clk); #1;
    end
    set_ordy(1'b0);
    total++;
    if (o_v !== 1'b0 || o_r !== 1'b1 || o_c !== 3'd0)
      $display("FAIL %s end got v=%b r=%b c=%0d want v=0 r=1 c=0",
               nm, o_v, o_r, o_c);
    else pass++;
  endtask

  task automatic load_sc1();
    push(32'd50, 8'd0, 1'b0);
    push(32'd20, 8'd1, 1'b0);
    push(32'd80, 8'd2, 1'b0);
    push(32'd10, 8'd3, 1'b0);
    push(32'd30, 8'd4, 1'b1);
    exp_sig[0] = 32'd10; exp_idx[0] = 8'd3;
    exp_sig[1] = 32'd20; exp_idx[1] = 8'd1;
    exp_sig[2] = 32'd30; exp_idx[2] = 8'd4;
    exp_sig[3] = 32'd50; exp_idx[3] = 8'd0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b0 ||
        ia.out_last !== 1'b0 || ia.out_count !== 3'd0 ||
        ia.out_signature !== 32'd0 || ia.out_index !== 8'd0)
      $display("FAIL reset_vals got r=%b v=%b l=%b c=%0d s=%0h",
               ia.in_ready, ia.out_valid, ia.out_last,
               ia.out_count, ia.out_signature);
    else pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1)
      $display("FAIL reset_release got=%b/%b want=1/1",
               ia.in_ready, ib.in_ready);
    else pass++;
  endtask

  task automatic test_sort();
    cur = 1'b0;
    load_sc1();
    total++;
    if (o_v !== 1'b1 || o_r !== 1'b0 || o_c !== 3'd4)
      $display("FAIL sort_enter got v=%b r=%b c=%0d want 1/0/4",
               o_v, o_r, o_c);
    else pass++;
    drain(4, "sort");
  endtask

  task automatic test_dedup();
    cur = 1'b0;
    push(32'd7, 8'd0, 1'b0);
    push(32'd7, 8'd1, 1'b0);
    push(32'd3, 8'd2, 1'b1);
    exp_sig[0] = 32'd3; exp_idx[0] = 8'd2;
    exp_sig[1] = 32'd7; exp_idx[1] = 8'd0;
    total++;
    if (o_c !== 3'd2)
      $display("FAIL dedup_peak got=%0d want=2", o_c);
    else pass++;
    drain(2, "dedup");
  endtask

  task automatic test_nodedup();
    cur = 1'b1;
    push(32'd7, 8'd0, 1'b0);
    push(32'd7, 8'd1, 1'b0);
    push(32'd3, 8'd2, 1'b1);
    exp_sig[0] = 32'd3; exp_idx[0] = 8'd2;
    exp_sig[1] = 32'd7; exp_idx[1] = 8'd0;
    exp_sig[2] = 32'd7; exp_idx[2] = 8'd1;
    drain(3, "nodedup");
    cur = 1'b0;
  endtask

  task automatic test_single();
    cur = 1'b0;
    push(32'hFFFF_FFFF, 8'd5, 1'b1);
    exp_sig[0] = 32'hFFFF_FFFF; exp_idx[0] = 8'd5;
    drain(1, "single");
  endtask

  task automatic test_backpressure();
    logic pat [6];
    int hs;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    cur = 1'b0;
    load_sc1();
    ia.in_valid = 1'b1;
    ia.in_signature = 32'd5;
    ia.in_index = 8'd9;
    ia.in_last = 1'b0;
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (o_v !== 1'b1 || o_r !== 1'b0 ||
          o_s !== exp_sig[hs] || o_i !== exp_idx[hs])
        $display("FAIL bp_beat[%0d] got v=%b r=%b %0d/%0d want 1/0 %0d/%0d",
                 k, o_v, o_r, o_s, o_i, exp_sig[hs], exp_idx[hs]);
      else pass++;
      ia.out_ready = pat[k];
      @(posedge clk); #1;
      if (pat[k]) hs++;
    end
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b0;
    total++;
    if (o_v !== 1'b0 || o_c !== 3'd0 || o_r !== 1'b1)
      $display("FAIL bp_end got v=%b c=%0d r=%b want 0/0/1",
               o_v, o_c, o_r);
    else pass++;
    @(posedge clk); #1;
    total++;
    if (o_c !== 3'd0)
      $display("FAIL bp_noaccept got=%0d want=0", o_c);
    else pass++;
  endtask

  task automatic test_reset_mid();
    cur = 1'b0;
    load_sc1();
    ia.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ia.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (o_v !== 1'b0 || o_c !== 3'd0 || o_r !== 1'b0 ||
        o_s !== 32'd0)
      $display("FAIL rst_mid got v=%b c=%0d r=%b s=%0h want 0/0/0/0",
               o_v, o_c, o_r, o_s);
    else pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'd9, 8'd1, 1'b1);
    exp_sig[0] = 32'd9; exp_idx[0] = 8'd1;
    drain(1, "rst_after");
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_signature = '0; ia.in_index = '0;
    ia.in_last = 1'b0;  ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_signature = '0; ib.in_index = '0;
    ib.in_last = 1'b0;  ib.out_ready = 1'b0;
    test_reset();
    test_sort();
    test_dedup();
    test_nodedup();
    test_single();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass, total);
    $fatal(1);
  end

endmodule
